// File: rtl/mem_rd_agent.sv
// mem_rd_agent: AXI4 read-traffic master.
// Sweeps a fixed address window with fixed-length INCR bursts and keeps up to
// OUTSTANDING_MAX bursts in flight. Every returned beat is passed straight into
// the downstream result FIFO. Saturating debug counters track AR handshakes,
// accepted R beats and error responses.
module mem_rd_agent #(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [2:0]            ARSIZE          = 3'b011,
    parameter int                    BURST_LEN       = 16,
    parameter int                    OUTSTANDING_MAX = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE       = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HIGH       = 32'h4000_2000,
    parameter int                    CNT_BITS        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // control
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           burst_count,
    output logic                  busy,
    output logic                  done,
    // AXI4 read address channel
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // AXI4 read data channel
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    // result FIFO write port
    output logic                  fifo_wrreq,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] fifo_data,
    // debug counters
    output logic [CNT_BITS-1:0]   dbg_ar_cnt,
    output logic [CNT_BITS-1:0]   dbg_beat_cnt,
    output logic [CNT_BITS-1:0]   dbg_err_cnt
);

    // Outstanding counter must be able to hold OUTSTANDING_MAX itself.
    localparam int                  OSW         = $clog2(OUTSTANDING_MAX + 1);
    localparam logic [OSW-1:0]      OUT_MAX     = OSW'(OUTSTANDING_MAX);
    // Address arithmetic is done one bit wider so a window ending at the very
    // top of the address space still compares correctly.
    localparam logic [ADDR_WIDTH:0] BURST_BYTES = (ADDR_WIDTH + 1)'(BURST_LEN * 8);
    localparam logic [ADDR_WIDTH:0] HIGH_EXT    = {1'b0, ADDR_HIGH};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int NUM_DBG = 3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_done;
    logic [31:0]           r_issued;
    logic [31:0]           r_count;
    logic [OSW-1:0]        r_outstanding;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_rlast_hs;
    logic                  w_dec;
    logic [OSW-1:0]        w_outstanding_next;
    logic [31:0]           w_issued_next;
    logic                  w_last_issue;
    logic                  w_can_issue;
    logic [ADDR_WIDTH:0]   w_addr_sum;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_counting;

    assign w_ar_hs    = r_arvalid & m_axi_arready;
    assign w_r_hs     = m_axi_rvalid & m_axi_rready;
    assign w_rlast_hs = w_r_hs & m_axi_rlast;

    // A burst completing with nothing on record (orphan data after a reset)
    // must not wrap the counter below zero.
    assign w_dec              = w_rlast_hs && (r_outstanding != '0);
    assign w_outstanding_next = r_outstanding + OSW'(w_ar_hs) - OSW'(w_dec);

    assign w_issued_next = r_issued + 32'(w_ar_hs);
    assign w_last_issue  = w_ar_hs && (r_count != 32'd0) && (w_issued_next == r_count);

    // Issue decision is made on post-handshake values so a freshly freed slot
    // (rlast this cycle) can be refilled on the very next cycle.
    assign w_can_issue = (w_outstanding_next < OUT_MAX)
                       && ((r_count == 32'd0) || (w_issued_next < r_count))
                       && !stop;

    assign w_addr_sum  = {1'b0, r_araddr} + BURST_BYTES;
    assign w_addr_next = (w_addr_sum >= HIGH_EXT) ? ADDR_BASE : w_addr_sum[ADDR_WIDTH-1:0];

    // Beats are only attributed to a run while the engine is active; data
    // still trickling in after a reset is forwarded but not counted.
    assign w_counting = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Control FSM, AR request generation and address sweep
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_araddr  <= ADDR_BASE;
            r_arvalid <= 1'b0;
            r_done    <= 1'b0;
            r_issued  <= 32'd0;
            r_count   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_araddr  <= ADDR_BASE;
                        r_issued  <= 32'd0;
                        r_count   <= burst_count;
                        r_done    <= 1'b0;
                        // Nothing is in flight in IDLE, so only stop can hold
                        // back the first request.
                        r_arvalid <= !stop;
                    end
                end
                S_RUN: begin
                    if (w_ar_hs) begin
                        r_araddr <= w_addr_next;
                        r_issued <= w_issued_next;
                    end
                    if (w_last_issue) begin
                        r_state   <= S_DRAIN;
                        r_arvalid <= 1'b0;
                    end else if (!r_arvalid && stop) begin
                        // stop only takes effect once no request is pending
                        r_state   <= S_DRAIN;
                        r_arvalid <= 1'b0;
                    end else if (!r_arvalid || w_ar_hs) begin
                        // a pending request is never withdrawn
                        r_arvalid <= w_can_issue;
                    end
                end
                S_DRAIN: begin
                    r_arvalid <= 1'b0;
                    // leave as the last rlast is accepted so done follows
                    // one cycle after it
                    if (w_outstanding_next == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Track bursts in flight: +1 per AR handshake, -1 per completed burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
        end
    end

    // ------------------------------------------------------------------
    // Debug counters: one saturating counter per event
    // ------------------------------------------------------------------
    logic [NUM_DBG-1:0]               w_cnt_evt;
    logic [NUM_DBG-1:0][CNT_BITS-1:0] w_dbg_cnt;

    assign w_cnt_evt[0] = w_ar_hs;
    assign w_cnt_evt[1] = w_r_hs && w_counting;
    assign w_cnt_evt[2] = w_r_hs && w_counting && (m_axi_rresp != 2'b00);

    generate
        for (genvar gi = 0; gi < NUM_DBG; gi++) begin : g_dbg
            logic [CNT_BITS-1:0] r_cnt;

            // Count the event, holding at all-ones instead of wrapping.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_cnt_evt[gi] && (r_cnt != {CNT_BITS{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_BITS'(1);
                end
            end

            assign w_dbg_cnt[gi] = r_cnt;
        end
    endgenerate

    assign dbg_ar_cnt   = w_dbg_cnt[0];
    assign dbg_beat_cnt = w_dbg_cnt[1];
    assign dbg_err_cnt  = w_dbg_cnt[2];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = ARSIZE;
    assign m_axi_arburst = 2'b01;

    // The FIFO is the only source of backpressure on the R channel; beats go
    // through in the same cycle they are accepted.
    assign m_axi_rready = !fifo_full;
    assign fifo_wrreq   = m_axi_rvalid && !fifo_full;
    assign fifo_data    = m_axi_rdata;

    assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done = r_done;

endmodule

// File: tb/tb_mem_rd_agent.sv
// Testbench for mem_rd_agent: an AXI read slave model feeds bursts back,
// expected AR addresses and expected FIFO data are queued when stimulus is
// produced and compared when the DUT hands them over.
module tb_mem_rd_agent;

    localparam int          DW   = 64;
    localparam int          AW   = 32;
    localparam int          BL   = 16;
    localparam int          CW   = 32;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [31:0]   burst_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          fifo_wrreq;
    logic          fifo_full;
    logic [DW-1:0] fifo_data;
    logic [CW-1:0] dbg_ar_cnt;
    logic [CW-1:0] dbg_beat_cnt;
    logic [CW-1:0] dbg_err_cnt;

    mem_rd_agent dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .burst_count   (burst_count),
        .busy          (busy),
        .done          (done),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .fifo_wrreq    (fifo_wrreq),
        .fifo_full     (fifo_full),
        .fifo_data     (fifo_data),
        .dbg_ar_cnt    (dbg_ar_cnt),
        .dbg_beat_cnt  (dbg_beat_cnt),
        .dbg_err_cnt   (dbg_err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // scoreboard queues
    logic [31:0] exp_ar_q[$];
    logic [63:0] exp_data_q[$];
    logic [31:0] pend_q[$];

    // slave model controls / observations
    int          ar_hs_cnt        = 0;
    int          wr_cnt           = 0;
    int          ar_budget        = -1;   // -1 unlimited
    int          r_bursts_allowed = -1;   // -1 unlimited
    int          err_left         = 0;
    bit          ar_rand          = 0;
    bit          r_gap            = 0;
    int          beat_idx         = 0;
    int          data_seq         = 0;
    bit          presenting       = 0;
    bit          prev_ar_stall    = 0;
    logic [31:0] prev_addr        = '0;
    logic [31:0] last_ar_addr     = '0;

    // bench-side expected debug counter totals
    int exp_ar_tot   = 0;
    int exp_beat_tot = 0;
    int exp_err_tot  = 0;

    function automatic logic [31:0] addr_of(input int i);
        return BASE + 32'((i * 128) % 8192);
    endfunction

    // AXI read slave + output monitor
    initial begin : slave
        logic [31:0] ea;
        logic [63:0] ed;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (prev_ar_stall && !rst) begin
                checks++;
                if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== prev_addr) begin
                    failures++;
                    $display("FAIL ar_stable: arvalid=%0b araddr=%h required arvalid=1 araddr=%h",
                             m_axi_arvalid, m_axi_araddr, prev_addr);
                end
            end
            prev_ar_stall = m_axi_arvalid && !m_axi_arready && !rst;
            prev_addr     = m_axi_araddr;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs_cnt++;
                if (ar_budget > 0) ar_budget--;
                checks++;
                if (exp_ar_q.size() == 0) begin
                    failures++;
                    $display("FAIL ar_unexpected: araddr=%h required no AR", m_axi_araddr);
                end else begin
                    ea = exp_ar_q.pop_front();
                    if (m_axi_araddr !== ea) begin
                        failures++;
                        $display("FAIL ar_addr: araddr=%h required %h", m_axi_araddr, ea);
                    end
                end
                checks++;
                if (m_axi_arlen !== 8'(BL - 1) || m_axi_arsize !== 3'b011 || m_axi_arburst !== 2'b01) begin
                    failures++;
                    $display("FAIL ar_fields: arlen=%0d arsize=%0d arburst=%0d required 15 3 1",
                             m_axi_arlen, m_axi_arsize, m_axi_arburst);
                end
                pend_q.push_back(m_axi_araddr);
                last_ar_addr = m_axi_araddr;
            end
            checks++;
            if (fifo_wrreq !== (m_axi_rvalid && !fifo_full) || m_axi_rready !== !fifo_full) begin
                failures++;
                $display("FAIL r_path: wrreq=%0b rready=%0b required wrreq=%0b rready=%0b",
                         fifo_wrreq, m_axi_rready, m_axi_rvalid && !fifo_full, !fifo_full);
            end
            if (fifo_wrreq) begin
                wr_cnt++;
                checks++;
                if (exp_data_q.size() == 0) begin
                    failures++;
                    $display("FAIL fifo_unexpected: data=%h required no write", fifo_data);
                end else begin
                    ed = exp_data_q.pop_front();
                    if (fifo_data !== ed) begin
                        failures++;
                        $display("FAIL fifo_data: data=%h required %h", fifo_data, ed);
                    end
                end
            end
            if (m_axi_rvalid && m_axi_rready) begin
                presenting = 0;
                if (m_axi_rlast) begin
                    if (pend_q.size() > 0) void'(pend_q.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            @(posedge clk);
            #1;
            m_axi_arready = (ar_budget != 0) && (!ar_rand || ($urandom_range(0, 1) == 1));
            if (!presenting) begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
                if (pend_q.size() > 0 && (beat_idx > 0 || r_bursts_allowed != 0)
                    && !(r_gap && ($urandom_range(0, 3) == 0))) begin
                    if (beat_idx == 0 && r_bursts_allowed > 0) r_bursts_allowed--;
                    presenting   = 1;
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = {16'hC0DE, 16'(beat_idx), 32'(data_seq)};
                    data_seq++;
                    m_axi_rlast  = (beat_idx == BL - 1);
                    if (err_left > 0) begin
                        m_axi_rresp = 2'b10;
                        err_left--;
                    end
                    exp_data_q.push_back(m_axi_rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [31:0] cnt);
        burst_count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; fifo_full = 1'b0; burst_count = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got %0b want 0", m_axi_arvalid); end
        checks++; if (m_axi_araddr !== BASE) begin failures++; $display("FAIL reset_araddr: got %h want %h", m_axi_araddr, BASE); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: got %0b %0b want 0 0", busy, done); end
        checks++; if (dbg_ar_cnt !== 0 || dbg_beat_cnt !== 0 || dbg_err_cnt !== 0) begin
            failures++; $display("FAIL reset_dbg: got %0d %0d %0d want 0 0 0", dbg_ar_cnt, dbg_beat_cnt, dbg_err_cnt);
        end
        checks++; if (m_axi_rready !== 1'b1) begin failures++; $display("FAIL reset_rready: got %0b want 1", m_axi_rready); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int w0;
        bit ok;
        exp_ar_q.push_back(BASE);
        ar_budget = -1; r_bursts_allowed = -1;
        w0 = wr_cnt;
        start_op(1);
        checks++; if (m_axi_arvalid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL single_first_ar: arvalid=%0b busy=%0b done=%0b want 1 1 0", m_axi_arvalid, busy, done);
        end
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_done: done=%0b want 1 within 200 cycles", done); end
        exp_ar_tot += 1; exp_beat_tot += 16;
        checks++; if (wr_cnt - w0 != 16) begin failures++; $display("FAIL single_wrreq: got %0d want 16", wr_cnt - w0); end
        checks++; if (dbg_ar_cnt !== CW'(exp_ar_tot) || dbg_beat_cnt !== CW'(exp_beat_tot)) begin
            failures++; $display("FAIL single_dbg: ar=%0d beat=%0d want %0d %0d", dbg_ar_cnt, dbg_beat_cnt, exp_ar_tot, exp_beat_tot);
        end
        checks++; if (exp_ar_q.size() != 0 || exp_data_q.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL single_leftover: ar_q=%0d data_q=%0d busy=%0b want 0 0 0", exp_ar_q.size(), exp_data_q.size(), busy);
        end
        $display("test_single done");
    endtask

    task automatic test_outstanding();
        int h0;
        bit ok;
        for (int i = 0; i < 17; i++) exp_ar_q.push_back(addr_of(i));
        ar_budget = -1; r_bursts_allowed = 0;
        h0 = ar_hs_cnt;
        start_op(0);
        repeat (40) tick();
        checks++; if (ar_hs_cnt - h0 != 16 || m_axi_arvalid !== 1'b0) begin
            failures++; $display("FAIL outst_limit: ars=%0d arvalid=%0b want 16 0", ar_hs_cnt - h0, m_axi_arvalid);
        end
        r_bursts_allowed = 1;
        repeat (40) tick();
        checks++; if (ar_hs_cnt - h0 != 17 || m_axi_arvalid !== 1'b0) begin
            failures++; $display("FAIL outst_refill: ars=%0d arvalid=%0b want 17 0", ar_hs_cnt - h0, m_axi_arvalid);
        end
        stop = 1'b1; r_bursts_allowed = -1;
        wait_done(800, ok);
        stop = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL outst_done: done=%0b want 1 within 800 cycles", done); end
        exp_ar_tot += 17; exp_beat_tot += 17 * 16;
        checks++; if (dbg_ar_cnt !== CW'(exp_ar_tot) || dbg_beat_cnt !== CW'(exp_beat_tot)) begin
            failures++; $display("FAIL outst_dbg: ar=%0d beat=%0d want %0d %0d", dbg_ar_cnt, dbg_beat_cnt, exp_ar_tot, exp_beat_tot);
        end
        $display("test_outstanding done");
    endtask

    task automatic test_wrap();
        int h0, w0;
        bit ok;
        for (int i = 0; i < 65; i++) exp_ar_q.push_back(addr_of(i));
        ar_rand = 1; r_gap = 1;
        h0 = ar_hs_cnt; w0 = wr_cnt;
        start_op(65);
        wait_done(5000, ok);
        ar_rand = 0; r_gap = 0;
        checks++; if (!ok) begin failures++; $display("FAIL wrap_done: done=%0b want 1 within 5000 cycles", done); end
        checks++; if (last_ar_addr !== BASE || ar_hs_cnt - h0 != 65) begin
            failures++; $display("FAIL wrap_last_ar: addr=%h ars=%0d want %h 65", last_ar_addr, ar_hs_cnt - h0, BASE);
        end
        checks++; if (wr_cnt - w0 != 1040) begin failures++; $display("FAIL wrap_beats: got %0d want 1040", wr_cnt - w0); end
        exp_ar_tot += 65; exp_beat_tot += 1040;
        checks++; if (dbg_ar_cnt !== CW'(exp_ar_tot) || dbg_beat_cnt !== CW'(exp_beat_tot)) begin
            failures++; $display("FAIL wrap_dbg: ar=%0d beat=%0d want %0d %0d", dbg_ar_cnt, dbg_beat_cnt, exp_ar_tot, exp_beat_tot);
        end
        $display("test_wrap done");
    endtask

    task automatic test_backpressure();
        int w0, w1, n;
        bit ok;
        bit bad;
        exp_ar_q.push_back(addr_of(0));
        exp_ar_q.push_back(addr_of(1));
        w0 = wr_cnt;
        start_op(2);
        n = 0;
        while (wr_cnt - w0 < 5 && n < 50) begin tick(); n++; end
        checks++; if (wr_cnt - w0 < 5) begin failures++; $display("FAIL bp_start: beats=%0d want >=5", wr_cnt - w0); end
        fifo_full = 1'b1;
        w1 = wr_cnt;
        bad = 0;
        repeat (10) begin
            tick();
            if (m_axi_rready !== 1'b0 || fifo_wrreq !== 1'b0 || m_axi_rvalid !== 1'b1) bad = 1;
        end
        checks++; if (bad || wr_cnt != w1) begin
            failures++; $display("FAIL bp_hold: rready=%0b wrreq=%0b writes=%0d want 0 0 0", m_axi_rready, fifo_wrreq, wr_cnt - w1);
        end
        fifo_full = 1'b0;
        wait_done(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_done: done=%0b want 1 within 300 cycles", done); end
        checks++; if (wr_cnt - w0 != 32 || exp_data_q.size() != 0) begin
            failures++; $display("FAIL bp_beats: got %0d left %0d want 32 0", wr_cnt - w0, exp_data_q.size());
        end
        exp_ar_tot += 2; exp_beat_tot += 32;
        $display("test_backpressure done");
    endtask

    task automatic test_err_stop();
        int h0, n;
        bit ok;
        bit bad;
        err_left = 3; ar_budget = 0;
        exp_ar_q.push_back(BASE);
        h0 = ar_hs_cnt;
        start_op(0);
        checks++; if (m_axi_arvalid !== 1'b1) begin failures++; $display("FAIL stop_first_ar: arvalid=%0b want 1", m_axi_arvalid); end
        repeat (3) tick();
        stop = 1'b1;
        bad = 0;
        repeat (2) begin
            tick();
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== BASE) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL stop_hold: arvalid=%0b araddr=%h want 1 %h", m_axi_arvalid, m_axi_araddr, BASE); end
        ar_budget = 1;
        n = 0;
        while (ar_hs_cnt - h0 < 1 && n < 10) begin tick(); n++; end
        checks++; if (ar_hs_cnt - h0 != 1) begin failures++; $display("FAIL stop_ar_done: ars=%0d want 1", ar_hs_cnt - h0); end
        bad = 0;
        repeat (20) begin
            tick();
            if (m_axi_arvalid !== 1'b0) bad = 1;
        end
        checks++; if (bad || ar_hs_cnt - h0 != 1) begin
            failures++; $display("FAIL stop_no_more_ar: ars=%0d want 1 with arvalid low", ar_hs_cnt - h0);
        end
        wait_done(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stop_done: done=%0b want 1 within 300 cycles", done); end
        stop = 1'b0; ar_budget = -1;
        exp_ar_tot += 1; exp_beat_tot += 16; exp_err_tot += 3;
        checks++; if (dbg_err_cnt !== CW'(exp_err_tot) || dbg_ar_cnt !== CW'(exp_ar_tot)) begin
            failures++; $display("FAIL err_cnt: err=%0d ar=%0d want %0d %0d", dbg_err_cnt, dbg_ar_cnt, exp_err_tot, exp_ar_tot);
        end
        $display("test_err_stop done");
    endtask

    task automatic test_reset_mid();
        int h0, w0, n;
        bit ok;
        ar_budget = 5; r_bursts_allowed = 0;
        for (int i = 0; i < 5; i++) exp_ar_q.push_back(addr_of(i));
        h0 = ar_hs_cnt;
        start_op(0);
        n = 0;
        while (ar_hs_cnt - h0 < 5 && n < 30) begin tick(); n++; end
        checks++; if (ar_hs_cnt - h0 != 5) begin failures++; $display("FAIL rmid_ars: got %0d want 5", ar_hs_cnt - h0); end
        repeat (2) tick();
        #1 rst = 1'b1;
        #1;
        checks++; if (m_axi_arvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_axi_araddr !== BASE) begin
            failures++; $display("FAIL rmid_async: arvalid=%0b busy=%0b done=%0b araddr=%h want 0 0 0 %h",
                                 m_axi_arvalid, busy, done, m_axi_araddr, BASE);
        end
        checks++; if (dbg_ar_cnt !== 0 || dbg_beat_cnt !== 0 || dbg_err_cnt !== 0) begin
            failures++; $display("FAIL rmid_dbg: got %0d %0d %0d want 0 0 0", dbg_ar_cnt, dbg_beat_cnt, dbg_err_cnt);
        end
        exp_ar_tot = 0; exp_beat_tot = 0; exp_err_tot = 0;
        repeat (2) tick();
        rst = 1'b0;
        ar_budget = -1; r_bursts_allowed = -1;
        w0 = wr_cnt;
        n = 0;
        while (pend_q.size() != 0 && n < 300) begin tick(); n++; end
        tick();
        checks++; if (wr_cnt - w0 != 80 || dbg_beat_cnt !== 0) begin
            failures++; $display("FAIL rmid_orphans: writes=%0d beat_cnt=%0d want 80 0", wr_cnt - w0, dbg_beat_cnt);
        end
        exp_ar_q.push_back(BASE);
        start_op(1);
        checks++; if (m_axi_arvalid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL rmid_restart: arvalid=%0b busy=%0b want 1 1", m_axi_arvalid, busy);
        end
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_done: done=%0b want 1 within 200 cycles", done); end
        exp_ar_tot += 1; exp_beat_tot += 16;
        checks++; if (dbg_ar_cnt !== CW'(exp_ar_tot) || dbg_beat_cnt !== CW'(exp_beat_tot)
                      || exp_ar_q.size() != 0 || exp_data_q.size() != 0) begin
            failures++; $display("FAIL rmid_final: ar=%0d beat=%0d ar_q=%0d data_q=%0d want %0d %0d 0 0",
                                 dbg_ar_cnt, dbg_beat_cnt, exp_ar_q.size(), exp_data_q.size(), exp_ar_tot, exp_beat_tot);
        end
        $display("test_reset_mid done");
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_outstanding();
        test_wrap();
        test_backpressure();
        test_err_stop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_rd_agent.md
# mem_rd_agent

AXI4 read-traffic master for the DDR memory agent. It sweeps a fixed address window with fixed-length INCR bursts and keeps up to a configurable number of bursts in flight. Every returned beat goes into the downstream result FIFO through a wrreq/full write port, and debug counters are maintained alongside. The block sits between the PS DDR slave port and the read-data FIFO, and it is the producer side of that FIFO.

## Interface
Parameters:
- DATA_WIDTH, 64: AXI read-data width and FIFO data width.
- ADDR_WIDTH, 32: AXI address width.
- ARSIZE, 3'b011: constant arsize (8 bytes per beat).
- BURST_LEN, 16: beats per burst, range 1..16; arlen = BURST_LEN-1.
- OUTSTANDING_MAX, 16: maximum bursts in flight.
- ADDR_BASE, 32'h4000_0000: first burst address.
- ADDR_HIGH, 32'h4000_2000: exclusive top of the window. (ADDR_HIGH-ADDR_BASE) must be a multiple of BURST_LEN*8.
- CNT_BITS, 32: debug counter width.

Ports:
- clk  in  1  the single clock; all logic is in this domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- stop  in  1  level; ends issuing early.
- burst_count  in  32  bursts to issue, sampled on start; 0 means run until stop.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  set on DRAIN->IDLE; held until the next accepted start or reset.
- m_axi_araddr  out  ADDR_WIDTH
- m_axi_arlen  out  8
- m_axi_arsize  out  3
- m_axi_arburst  out  2  constant 2'b01.
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- fifo_wrreq  out  1
- fifo_full  in  1
- fifo_data  out  DATA_WIDTH
- dbg_ar_cnt  out  CNT_BITS  AR handshakes.
- dbg_beat_cnt  out  CNT_BITS  R beats accepted.
- dbg_err_cnt  out  CNT_BITS  beats with rresp != 0.

## Operation
- States are IDLE, RUN and DRAIN.
  - IDLE->RUN on start: araddr<=ADDR_BASE, issued<=0, done<=0, and burst_count is latched.
  - RUN->DRAIN when the final AR handshake occurs (issued reaches the latched count, count != 0), or when stop=1 with arvalid low.
  - DRAIN->IDLE when outstanding==0, with done<=1 at the same time.
- AR issue:
  - In RUN, arvalid asserts when outstanding < OUTSTANDING_MAX, issued < count (or count==0), and stop=0.
  - Once arvalid is asserted, it and araddr stay stable until arready. stop never withdraws a pending request.
- Address update on each AR handshake:
  - next = araddr + BURST_LEN*8.
  - If next >= ADDR_HIGH, araddr wraps to ADDR_BASE; otherwise araddr <= next.
- outstanding, a counter of $clog2(OUTSTANDING_MAX+1) bits:
  - +1 on an AR handshake.
  - -1 on an R handshake with rlast=1.
  - Unchanged when both happen in the same cycle.
- R path:
  - rready = !fifo_full, combinational.
  - fifo_wrreq = rvalid & rready.
  - fifo_data = rdata, a combinational pass-through.
  - No beat is dropped; backpressure reaches AXI only through fifo_full.
- Debug counters:
  - Each increments by 1 on its event and saturates at all-ones.
  - Cleared only by rst; start does not clear them.
- start in RUN or DRAIN is ignored.

## Timing
- Reset values: arvalid=0, araddr=ADDR_BASE, busy=0, done=0, all dbg_*=0, outstanding=0, state=IDLE.
- arlen, arsize and arburst are constants.
- Reset mid-transfer returns the block to IDLE immediately. Beats arriving afterwards still see rready = !fifo_full and are pushed, but they are not counted and do not underflow outstanding; the decrement is suppressed at 0.
- The first arvalid rises the cycle after start is sampled.
- Back-to-back AR is possible every cycle while arready=1 and the limit allows.
- R-to-FIFO latency is 0 cycles (same-cycle wrreq).
- When outstanding==OUTSTANDING_MAX and an rlast handshake occurs, arvalid may assert the next cycle.
- done rises the cycle after the last rlast handshake in DRAIN.

## Test plan
- Single burst: burst_count=1, arready=1, 16 beats returned with rlast on beat 16 -> one AR at 0x4000_0000 with arlen=15, 16 wrreq, done=1, dbg_ar_cnt=1, dbg_beat_cnt=16.
- Outstanding limit: burst_count=0, arready=1, rvalid=0 -> exactly 16 AR handshakes, then arvalid=0. One completed burst -> exactly one more AR.
- Wrap: burst_count=65, BURST_LEN=16 -> AR 64 at 0x4000_1F80, AR 65 at 0x4000_0000, done after 1040 beats.
- Backpressure: fifo_full=1 for 10 cycles mid-burst with rvalid=1 -> rready=0 and wrreq=0 throughout. Resumes with no lost or duplicated beats (rdata sequence intact).
- Error and stop: rresp=2'b10 on 3 beats -> dbg_err_cnt=3. stop asserted while arvalid=1 and arready=0 -> the AR completes, no further AR, DRAIN, done.
- Reset mid-operation: rst asserted with 5 bursts outstanding -> outputs return to their reset values asynchronously. After release, start issues from 0x4000_0000.
